// File: rtl/shift_seq_ctrl.sv
// Full-duplex serializer/deserializer sequencer: MSB-first transmit on sdo while
// sdi is shifted into a receive register, followed by a programmable idle gap.
module shift_seq_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             abort,
   input  logic             sdi,
   output logic             sdo,
   output logic             shift_en,
   output logic             busy,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [CNT_W-1:0] cnt;
   logic [GAP_W-1:0] gcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      shift_en    = 1'b0;
      busy        = 1'b0;
      sdo         = 1'b0;
      case (state)
         S_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_next = S_SHIFT;
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            busy     = 1'b1;
            sdo      = tx_sr[WIDTH-1];
            // abort takes priority over completion of the final bit
            if (abort)             state_next = S_IDLE;
            else if (cnt == LAST)  state_next = (GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            busy = 1'b1;
            if (abort || gcnt == GAP_W'(1)) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_sr    <= '0;
         rx_sr    <= '0;
         cnt      <= '0;
         gcnt     <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  tx_sr <= tx_data;
                  rx_sr <= '0;
                  cnt   <= '0;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  tx_sr <= '0;
                  cnt   <= '0;
               end else begin
                  tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                  rx_sr <= {rx_sr[WIDTH-2:0], sdi};
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     rx_data  <= {rx_sr[WIDTH-2:0], sdi};
                     rx_valid <= 1'b1;
                     gcnt     <= GAP_LD;
                     cnt      <= '0;
                  end
               end
            end
            S_GAP: begin
               if (abort) gcnt <= '0;
               else       gcnt <= gcnt - GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: a frame-level model predicts per-cycle
// outputs and received words; a negedge monitor pops and compares.
module tb_shift_seq_ctrl;

   localparam int W = 4;
   localparam int G = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         sv, abort, sdi;
   logic [W-1:0] txd;
   logic         start_ready, sdo, shift_en, busy, rx_valid;
   logic [W-1:0] rx_data;

   logic         sv0, sdi0;
   logic [W-1:0] txd0;
   logic         sr0, sdo0, se0, bz0, rv0;
   logic [W-1:0] rxd0;

   shift_seq_ctrl #(.WIDTH(W), .GAP(G)) u_dut (
      .clk(clk), .rst(rst), .start_valid(sv), .start_ready(start_ready),
      .tx_data(txd), .abort(abort), .sdi(sdi), .sdo(sdo), .shift_en(shift_en),
      .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid)
   );

   shift_seq_ctrl #(.WIDTH(W), .GAP(0)) u_dut0 (
      .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(sr0),
      .tx_data(txd0), .abort(1'b0), .sdi(sdi0), .sdo(sdo0), .shift_en(se0),
      .busy(bz0), .rx_data(rxd0), .rx_valid(rv0)
   );

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic         sr, se, bz, sdo, rv;
      logic [W-1:0] rxd;
   } exp_t;

   exp_t         cyc_q[$];
   logic [W-1:0] frame_q[$];
   bit           mon_en = 1'b0;

   // model: phase 0 idle, 1..W = index of bit on the wire, W+1..W+G = gap cycles
   int           phase;
   int           m_word, m_rx, m_last;
   bit           m_rxv;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      phase  = 0;
      m_word = 0;
      m_rx   = 0;
      m_last = 0;
      m_rxv  = 1'b0;
   endtask

   // One clock cycle: record expected outputs, apply inputs, advance the model.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic ab,
                        input logic s, output bit hs);
      exp_t e;
      @(posedge clk);
      #2;
      e.sr  = (phase == 0);
      e.se  = (phase >= 1 && phase <= W);
      e.bz  = (phase != 0);
      e.sdo = e.se ? logic'((m_word >> (W - phase)) & 1) : 1'b0;
      e.rv  = m_rxv;
      e.rxd = W'(m_last);
      cyc_q.push_back(e);
      sv = v; txd = d; abort = ab; sdi = s;
      hs    = 1'b0;
      m_rxv = 1'b0;
      if (phase == 0) begin
         if (v) begin
            hs = 1'b1; phase = 1; m_word = int'(d); m_rx = 0;
         end
      end else if (ab) begin
         phase = 0;
      end else if (phase <= W) begin
         m_rx = ((m_rx << 1) | int'(s)) & ((1 << W) - 1);
         if (phase == W) begin
            m_last = m_rx;
            m_rxv  = 1'b1;
            frame_q.push_back(W'(m_rx));
            phase = (G == 0) ? 0 : W + 1;
         end else begin
            phase++;
         end
      end else begin
         phase = (phase >= W + G) ? 0 : phase + 1;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (cyc_q.size() != 0) begin
            exp_t e;
            e = cyc_q.pop_front();
            chk("start_ready", 32'(start_ready), 32'(e.sr));
            chk("shift_en",    32'(shift_en),    32'(e.se));
            chk("busy",        32'(busy),        32'(e.bz));
            chk("sdo",         32'(sdo),         32'(e.sdo));
            chk("rx_valid",    32'(rx_valid),    32'(e.rv));
            chk("rx_data_hold", 32'(rx_data),    32'(e.rxd));
         end
         if (rx_valid) begin
            if (frame_q.size() == 0) begin
               chk("spurious_rx_valid", 32'(1), 32'(0));
            end else begin
               chk("rx_word", 32'(rx_data), 32'(frame_q.pop_front()));
            end
         end
      end
   end

   initial begin
      bit           hs;
      int           idx;
      int           acc, prev;
      logic [W-1:0] w;
      logic         s;
      logic [W-1:0] words[2];
      logic [3:0]   sdi_pat;

      sv = 0; abort = 0; sdi = 0; txd = '0;
      sv0 = 0; sdi0 = 0; txd0 = '0;
      model_reset();
      rst = 1'b0;
      #1;
      chk("reset_start_ready", 32'(start_ready), 32'(1));
      chk("reset_busy",        32'(busy),        32'(0));
      chk("reset_rx_data",     32'(rx_data),     32'(0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      mon_en = 1'b1;

      // single frame: 1011 out, sdi 0,1,1,0 in
      sdi_pat = 4'b0110;
      cycle(1'b1, 4'b1011, 1'b0, 1'b0, hs);
      for (int b = 0; b < W; b++) cycle(1'b0, '0, 1'b0, sdi_pat[W-1-b], hs);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, hs);

      // back-to-back with start_valid held high
      words[0] = 4'hA; words[1] = 4'h5; idx = 0;
      for (int c = 0; c < 2 * (W + G + 1) + 2; c++) begin
         cycle(idx < 2, (idx < 2) ? words[idx] : 4'h0, 1'b0, 1'($urandom_range(0, 1)), hs);
         if (hs) idx++;
      end

      // abort in the 2nd SHIFT cycle, then immediate new handshake
      cycle(1'b1, 4'h9, 1'b0, 1'b1, hs);
      cycle(1'b0, '0, 1'b0, 1'b1, hs);
      cycle(1'b0, '0, 1'b1, 1'b1, hs);
      cycle(1'b1, 4'h6, 1'b0, 1'b0, hs);
      for (int b = 0; b < W + G + 1; b++) cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), hs);

      // abort coinciding with the final SHIFT edge
      cycle(1'b1, 4'hC, 1'b0, 1'b1, hs);
      for (int b = 0; b < W; b++) cycle(1'b0, '0, b == W - 1, 1'b1, hs);
      repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, hs);

      // abort in IDLE together with a handshake, then busy stimulus of 4'hF
      cycle(1'b1, 4'h3, 1'b1, 1'b1, hs);
      for (int b = 0; b < W + G; b++) cycle(1'b1, 4'hF, 1'b0, 1'($urandom_range(0, 1)), hs);
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, hs);

      // asynchronous reset mid-frame
      cycle(1'b1, 4'hE, 1'b0, 1'b1, hs);
      cycle(1'b0, '0, 1'b0, 1'b1, hs);
      cycle(1'b0, '0, 1'b0, 1'b1, hs);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      cyc_q.delete();
      frame_q.delete();
      sv = 0;
      rst = 1'b0;
      #1;
      chk("async_rst_start_ready", 32'(start_ready), 32'(1));
      chk("async_rst_shift_en",    32'(shift_en),    32'(0));
      chk("async_rst_busy",        32'(busy),        32'(0));
      chk("async_rst_sdo",         32'(sdo),         32'(0));
      chk("async_rst_rx_valid",    32'(rx_valid),    32'(0));
      chk("async_rst_rx_data",     32'(rx_data),     32'(0));
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1 chk("release_start_ready", 32'(start_ready), 32'(1));
      chk("release_rx_valid", 32'(rx_valid), 32'(0));
      mon_en = 1'b1;

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         cycle(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 19) == 0,
               1'($urandom_range(0, 1)), hs);
      end
      for (int c = 0; c < W + G + 2; c++) cycle(1'b0, '0, 1'b0, 1'b0, hs);
      chk("frames_outstanding", 32'(frame_q.size()), 32'(0));
      mon_en = 1'b0;

      // GAP=0 instance: continuous start_valid gives a 5-cycle frame period
      prev = 0;
      for (int f = 0; f < 6; f++) begin
         w = W'($urandom);
         @(posedge clk);
         #2 sv0 = 1'b1; txd0 = w;
         @(negedge clk);
         chk("g0_start_ready", 32'(sr0), 32'(1));
         chk("g0_shift_en_idle", 32'(se0), 32'(0));
         chk("g0_rx_valid_idle", 32'(rv0), 32'(f > 0));
         if (f > 0) chk("g0_rx_word", 32'(rxd0), 32'(prev));
         acc = 0;
         for (int b = 0; b < W; b++) begin
            @(posedge clk);
            #2;
            sv0  = 1'($urandom_range(0, 1));
            txd0 = W'($urandom);
            s    = 1'($urandom_range(0, 1));
            sdi0 = s;
            acc  = ((acc << 1) | int'(s)) & ((1 << W) - 1);
            @(negedge clk);
            chk("g0_shift_en", 32'(se0), 32'(1));
            chk("g0_busy", 32'(bz0), 32'(1));
            chk("g0_sdo", 32'(sdo0), 32'((int'(w) >> (W - 1 - b)) & 1));
            chk("g0_rx_valid_shift", 32'(rv0), 32'(0));
         end
         prev = acc;
      end
      @(posedge clk);
      #2 sv0 = 1'b0;
      @(negedge clk);
      chk("g0_final_rx_valid", 32'(rv0), 32'(1));
      chk("g0_final_start_ready", 32'(sr0), 32'(1));
      chk("g0_final_rx_word", 32'(rxd0), 32'(prev));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for a WIDTH-bit left-shift register pair, used as a full-duplex serializer/deserializer.
- Accepts a parallel word through a valid/ready handshake.
- Shifts it out MSB-first on sdo for exactly WIDTH cycles while shifting sdi into a receive register.
- Presents the received word with a one-cycle valid pulse, then enforces a programmable idle gap.
- Sits between a parallel producer/consumer and a bit-serial link.

Parameters:
WIDTH, 4, word length in bits; must be >= 2.
GAP, 1, idle cycles inserted after each frame before start_ready re-asserts; 0 allowed.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  reset, asynchronous, active-low; clears all state immediately on its falling edge.
start_valid  input  1  producer has a word on tx_data.
start_ready  output  1  block can accept a word; high only in IDLE.
tx_data  input  WIDTH  parallel word to transmit; sampled only on handshake.
abort  input  1  synchronous cancel of the current frame.
sdi  input  1  serial receive bit; sampled on each SHIFT-cycle edge.
sdo  output  1  serial transmit bit; equals MSB of tx shift register in SHIFT, 0 otherwise.
shift_en  output  1  high exactly during the WIDTH SHIFT cycles.
busy  output  1  high in SHIFT and GAP.
rx_data  output  WIDTH  last completed received word; holds until the next completion.
rx_valid  output  1  one-cycle pulse when rx_data updates.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; tx_sr, rx_sr, bit counter, gap counter, rx_data = 0.
  - rx_valid=0, sdo=0, shift_en=0, busy=0, start_ready=1.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - start_ready=1.
  - Handshake = start_valid && start_ready at a rising edge: tx_sr<=tx_data, rx_sr<=0, cnt<=0, state<=SHIFT.
  - No handshake: state is held.
- SHIFT:
  - Outputs: shift_en=1, busy=1, sdo=tx_sr[WIDTH-1].
  - Each edge: tx_sr<={tx_sr[WIDTH-2:0],1'b0}; rx_sr<={rx_sr[WIDTH-2:0],sdi}; cnt<=cnt+1.
  - Edge with cnt==WIDTH-1:
    - rx_data<={rx_sr[WIDTH-2:0],sdi}; rx_valid<=1 (high for the following cycle only).
    - state<=GAP with gap counter loaded to GAP, or state<=IDLE if GAP==0.
- GAP:
  - busy=1, start_ready=0.
  - Gap counter decrements each cycle; state<=IDLE when it reaches 1.
  - start_valid is ignored.
- Latency for a handshake at edge k:
  - SHIFT occupies cycles k+1..k+WIDTH.
  - rx_valid is high in cycle k+WIDTH+1.
  - start_ready re-asserts in cycle k+WIDTH+1+GAP.
  - Back-to-back frame period = WIDTH+GAP+1 cycles.
- Counter widths: cnt is $clog2(WIDTH) bits minimum; the gap counter is wide enough for GAP. There is no wrap beyond WIDTH-1.
- abort (any state except IDLE):
  - state<=IDLE at the next edge; tx_sr and cnt are cleared.
  - rx_data is unchanged and no rx_valid is produced.
  - If abort coincides with the final SHIFT edge, abort wins: no rx_valid, rx_data unchanged.
  - abort in IDLE has no effect, and does not block a same-cycle handshake.
- start_valid while busy: ignored; the word must be held by the producer until start_ready.
- tx_data changes after the handshake: no effect on the frame in progress.
- rst mid-frame: immediate return to reset values; no partial rx_valid.

Test Plan:
- Reset: assert rst low for 3 cycles mid-operation -> all outputs at reset values asynchronously; start_ready=1 on release.
- Single frame (WIDTH=4, GAP=1): tx_data=4'b1011 accepted at edge 0, sdi=0,1,1,0 in SHIFT cycles ->
  - sdo=1,0,1,1 with shift_en high cycles 1-4;
  - rx_data=4'b0110 and rx_valid=1 in cycle 5 only;
  - start_ready=1 in cycle 6.
- Back-to-back: start_valid held high with words 4'hA then 4'h5 -> second handshake exactly 6 cycles after the first; sdo streams 1,0,1,0 then 0,1,0,1.
- Abort: abort pulsed in the 2nd SHIFT cycle -> IDLE next cycle, sdo=0, no rx_valid, rx_data retains its previous value; a new handshake is accepted the following cycle.
- Busy stimulus: start_valid pulsed with tx_data=4'hF during SHIFT and GAP -> ignored; the current frame is unaffected and no extra frame is sent.
- GAP=0 variant: continuous start_valid -> frame period of 5 cycles; rx_valid coincides with start_ready high.
